uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync2.sv | 27 ++
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling default and
// 8N1 frame constants.
package uart_pkg;

  localparam int OVS_DEFAULT = 16;  // brg_en ticks per bit period
  localparam int DATA_BITS   = 8;   // 8N1: eight data bits, LSB first
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so an idle-high line does not fake an edge out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the asynchronous input, then let the first flop settle one cycle.
  // NOTE: sequential logic uses non-blocking assignments so both flops sample
  // their inputs at the same edge and form a true two-stage shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a shared oversampling baud tick (brg_en).
// Start bit is validated at its midpoint, data and stop bits are sampled at
// their midpoints, and the completed byte is held with rdy/error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVS = OVS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       brg_en,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_TICK = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;

  // Line idles high, so the synchronizer resets high to avoid a false start.
  sync2 #(.RST_VAL(IDLE_LVL)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (RX),
    .q    (rx_s)
  );

  // Receiver FSM with counters, shift register and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift register and rx_data are plain flops, not a memory,
      // so they are reset like any other state to give a defined 0x00 output.
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      rx_data <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      // NOTE: consumer acknowledge is applied first; a byte completing in the
      // same cycle assigns rdy/ovr_err later below, and the last assignment wins.
      if (clr_rdy) begin
        rdy     <= 1'b0;
        ovr_err <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          // Start detect works every cycle, not only on brg_en.
          if (rx_s == START_LVL) begin
            state <= START;
            tick  <= '0;
          end
        end

        START: begin
          if (brg_en) begin
            if (tick == HALF_TICK) begin
              if (rx_s == START_LVL) begin
                state   <= DATA;
                tick    <= '0;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;  // too short to be a start bit
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end

        DATA: begin
          if (brg_en) begin
            if (tick == LAST_TICK) begin
              tick    <= '0;
              shift   <= {rx_s, shift[DATA_BITS-1:1]};  // LSB arrives first
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) state <= STOP;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end

        STOP: begin
          if (brg_en) begin
            if (tick == LAST_TICK) begin
              tick    <= '0;
              rx_data <= shift;
              rdy     <= 1'b1;
              frm_err <= (rx_s != STOP_LVL);
              // Overrun only when the previous byte is still unacknowledged;
              // an acknowledge in this very cycle leaves ovr_err as it was.
              if (clr_rdy)  ovr_err <= ovr_err;
              else if (rdy) ovr_err <= 1'b1;
              state <= IDLE;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames for the key corner cases
// plus randomized frames compared against a frame-level reference model.
module tb_uart_rx;

  localparam int OVS     = 16;
  localparam int BRG_DIV = 4;            // clocks per brg_en period
  localparam int STOP_P  = 16 + 8 * 16;  // first brg period of the stop bit
  localparam int DONE_P  = STOP_P + OVS / 2;  // brg period that samples stop

  logic       clk;
  logic       rst_n;
  logic       RX;
  logic       brg_en;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  int checks;
  int errors;

  // Frame-level model of the receiver's visible state.
  logic [7:0] m_data;
  logic       m_rdy;
  logic       m_frm;
  logic       m_ovr;

  uart_rx #(.OVS(OVS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .brg_en (brg_en),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy    (rdy),
    .frm_err(frm_err),
    .ovr_err(ovr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rx_data"}, 32'(rx_data), 32'(m_data));
    check({tag, ".rdy"},     32'(rdy),     32'(m_rdy));
    check({tag, ".frm_err"}, 32'(frm_err), 32'(m_frm));
    check({tag, ".ovr_err"}, 32'(ovr_err), 32'(m_ovr));
  endtask

  task automatic model_reset();
    m_data = 8'h00;
    m_rdy  = 1'b0;
    m_frm  = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // One brg_en period on an unchanging line.
  task automatic idle_period(input logic line);
    @(negedge clk);
    RX     = line;
    brg_en = 1'b1;
    @(negedge clk);
    brg_en = 1'b0;
    repeat (BRG_DIV - 2) @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Line level during brg period p of a frame (16 periods per bit).
  // A bad stop bit is held low just past its midpoint, then released so the
  // receiver's immediate restart is rejected as a glitch.
  function automatic logic frame_level(input logic [7:0] d, input bit stop_ok, input int p);
    if (p < 16)     return 1'b0;
    if (p < STOP_P) return d[(p - 16) / 16];
    if (p < STOP_P + 16) return stop_ok ? 1'b1 : (p < DONE_P + 2 ? 1'b0 : 1'b1);
    return 1'b1;
  endfunction

  // Send one frame; optionally acknowledge in the completion cycle or pulse
  // reset at brg period rst_at (frame then abandoned, line back to idle).
  task automatic send_frame(input string tag, input logic [7:0] d, input bit stop_ok,
                            input bit clr_same, input int rst_at);
    logic pre;
    logic post;
    logic rdy_before;
    pre = 1'b0;
    post = 1'b0;
    for (int p = 0; p < STOP_P + 20; p++) begin
      @(negedge clk);
      RX      = frame_level(d, stop_ok, p);
      brg_en  = 1'b1;
      clr_rdy = clr_same && (p == DONE_P);
      if (p == DONE_P) pre = rdy;
      if (p == rst_at) rst_n = 1'b0;
      @(negedge clk);
      brg_en  = 1'b0;
      clr_rdy = 1'b0;
      if (p == DONE_P) post = rdy;
      if (p == rst_at) begin
        rst_n = 1'b1;
        RX    = 1'b1;
        model_reset();
        return;
      end
      if (p == DONE_P) begin
        rdy_before = m_rdy;
        check({tag, ".rdy_pre"},  32'(pre),  32'(rdy_before));
        check({tag, ".rdy_post"}, 32'(post), 32'(1));
        if (!clr_same && rdy_before) m_ovr = 1'b1;
        m_rdy  = 1'b1;
        m_data = d;
        m_frm  = !stop_ok;
      end
      repeat (BRG_DIV - 2) @(negedge clk);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    RX      = 1'b1;
    brg_en  = 1'b0;
    clr_rdy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
    repeat (4) idle_period(1'b1);

    // Basic byte.
    send_frame("a5", 8'hA5, 1'b1, 1'b0, -1);
    check_outputs("a5");
    do_clr();
    check_outputs("a5_clr");

    // Short low glitch must be rejected, then a real frame received.
    for (int i = 0; i < 4; i++) idle_period(1'b0);
    for (int i = 0; i < 20; i++) idle_period(1'b1);
    check_outputs("glitch");
    send_frame("3c", 8'h3C, 1'b1, 1'b0, -1);
    check_outputs("3c");
    do_clr();

    // Framing error still delivers the byte; next good byte clears it.
    send_frame("81_bad", 8'h81, 1'b0, 1'b0, -1);
    check_outputs("81_bad");
    do_clr();
    send_frame("55", 8'h55, 1'b1, 1'b0, -1);
    check_outputs("55");
    do_clr();

    // Overrun.
    send_frame("11", 8'h11, 1'b1, 1'b0, -1);
    send_frame("22", 8'h22, 1'b1, 1'b0, -1);
    check_outputs("ovr");
    do_clr();
    check_outputs("ovr_clr");

    // Acknowledge coinciding with completion: set wins.
    send_frame("7e", 8'h7E, 1'b1, 1'b1, -1);
    check_outputs("7e_same");
    do_clr();

    // Reset during data bit 4, then a clean frame.
    send_frame("ff_rst", 8'hFF, 1'b1, 1'b0, 16 + 4 * 16 + 5);
    check_outputs("ff_rst");
    for (int i = 0; i < 200; i++) idle_period(1'b1);
    check_outputs("ff_rst_idle");
    send_frame("0f", 8'h0F, 1'b1, 1'b0, -1);
    check_outputs("0f");

    // Randomized frames against the model.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      bit stop_ok;
      bit clr_same;
      d        = 8'($urandom);
      stop_ok  = ($urandom_range(0, 3) != 0);
      clr_same = ($urandom_range(0, 5) == 0);
      send_frame($sformatf("rnd%0d", n), d, stop_ok, clr_same, -1);
      check_outputs($sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) begin
        do_clr();
        check_outputs($sformatf("rnd%0d_clr", n));
      end
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) idle_period(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
